// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM access sequencer.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_SETUP = 3'd1,
    ST_WR_PULSE = 3'd2,
    ST_WR_RECOV = 3'd3,
    ST_RD_PULSE = 3'd4,
    ST_RSP      = 3'd5
  } state_t;

  localparam int MIN_WR_PULSE = 1;
  localparam int MIN_RD_PULSE = 2;
  localparam int unsigned MAX_ROWS = 64;

  // Wordline vector for a row address; all-zero when the row does not exist.
  function automatic logic [MAX_ROWS-1:0] onehot_row(input int unsigned addr, input int unsigned rows);
    logic [MAX_ROWS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_ROWS; i++) begin
      v[i] = (i < rows) && (i == addr);
    end
    return v;
  endfunction

endpackage

// File: rtl/sram_pulse_timer.sv
// Loadable down-counter timing the wordline pulses; done marks the final pulse cycle.
module sram_pulse_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  localparam logic [CW-1:0] ONE = CW'(1'b1);

  logic [CW-1:0] count_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r > ONE) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == ONE);

endmodule

// File: rtl/sram_ctrl.sv
// SRAM access sequencer: turns valid/ready requests into timed wordline, driver and sense strobes.
// Optional write-back verification is enabled by defining SRAM_CTRL_WRITE_VERIFY_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ROWS     = 2,
  parameter int COLS     = 8,
  parameter int WR_PULSE = 4,
  parameter int RD_PULSE = 4,
  parameter int AW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [ROWS-1:0] row_wr_en,
  output logic [ROWS-1:0] row_rd_en,
  output logic [COLS-1:0] wdata_drv,
  output logic            wdata_oe,
  output logic            sa_en,
  input  logic [COLS-1:0] sa_dout
);

  localparam int WR_LEN  = (WR_PULSE < MIN_WR_PULSE) ? MIN_WR_PULSE : WR_PULSE;
  localparam int RD_LEN  = (RD_PULSE < MIN_RD_PULSE) ? MIN_RD_PULSE : RD_PULSE;
  localparam int MAX_LEN = (WR_LEN > RD_LEN) ? WR_LEN : RD_LEN;
  localparam int CW      = $clog2(MAX_LEN) + 1;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
  localparam logic VERIFY = 1'b1;
`else
  localparam logic VERIFY = 1'b0;
`endif

  state_t          state_r, next_state_s;
  logic            init_done_r;
  logic            we_r;
  logic [AW-1:0]   addr_r;
  logic [COLS-1:0] wdata_r;
  logic [COLS-1:0] rdata_r;
  logic            err_r;
  logic [ROWS-1:0] row_sel_s;
  logic            in_range_s;
  logic            accept_s;
  logic            timer_load_s;
  logic [CW-1:0]   timer_val_s;
  logic            timer_done_s;
  logic            capture_s;

  assign row_sel_s  = ROWS'(onehot_row(32'(addr_r), ROWS));
  assign in_range_s = |row_sel_s;
  assign accept_s   = req_valid && req_ready;
  assign capture_s  = (state_r == ST_RD_PULSE) && timer_done_s;

  // The shared timer is reloaded whenever a pulse state is freshly entered.
  assign timer_load_s = (next_state_s != state_r) &&
                        ((next_state_s == ST_WR_PULSE) || (next_state_s == ST_RD_PULSE));
  assign timer_val_s  = (next_state_s == ST_WR_PULSE) ? CW'(WR_LEN) : CW'(RD_LEN);

  sram_pulse_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .done     (timer_done_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      init_done_r <= 1'b1;
    end
  end

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = req_we ? ST_WR_SETUP : ST_RD_PULSE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WR_SETUP: next_state_s = ST_WR_PULSE;
      ST_WR_PULSE: next_state_s = timer_done_s ? ST_WR_RECOV : ST_WR_PULSE;
      ST_WR_RECOV: next_state_s = VERIFY ? ST_RD_PULSE : ST_IDLE;
      ST_RD_PULSE: next_state_s = timer_done_s ? ST_RSP : ST_RD_PULSE;
      ST_RSP:      next_state_s = rsp_ready ? ST_IDLE : ST_RSP;
      default:     next_state_s = ST_IDLE;
    endcase
  end

  // Request fields are latched at accept; sensed data is captured at the end of the last read cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        we_r    <= req_we;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      if (capture_s) begin
        rdata_r <= in_range_s ? sa_dout : '0;
        err_r   <= !in_range_s || (VERIFY && we_r && (sa_dout != wdata_r));
      end
    end
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    row_wr_en = '0;
    row_rd_en = '0;
    wdata_drv = '0;
    wdata_oe  = 1'b0;
    sa_en     = 1'b0;
    case (state_r)
      ST_IDLE: req_ready = init_done_r;
      ST_WR_SETUP, ST_WR_RECOV: begin
        wdata_oe  = 1'b1;
        wdata_drv = wdata_r;
      end
      ST_WR_PULSE: begin
        wdata_oe  = 1'b1;
        wdata_drv = wdata_r;
        row_wr_en = row_sel_s;
      end
      ST_RD_PULSE: begin
        row_rd_en = row_sel_s;
        sa_en     = timer_done_s;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_r;
        rsp_err   = err_r;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized self-checking bench for sram_ctrl with a behavioural array model attached.
module tb_sram_ctrl;

  localparam int ROWS = 3;
  localparam int COLS = 8;
  localparam int WP   = 4;
  localparam int RP   = 4;
  localparam int AW   = 2;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready, req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [COLS-1:0] rsp_rdata;
  logic [ROWS-1:0] row_wr_en, row_rd_en;
  logic [COLS-1:0] wdata_drv, sa_dout;
  logic            wdata_oe, sa_en;

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] ref_mem [ROWS];
  logic            mem_clr;
  logic            stuck_en;
  logic [COLS-1:0] stuck_val;
  int              n_total = 0;
  int              n_pass  = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.ROWS(ROWS), .COLS(COLS), .WR_PULSE(WP), .RD_PULSE(RP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .row_wr_en(row_wr_en), .row_rd_en(row_rd_en),
    .wdata_drv(wdata_drv), .wdata_oe(wdata_oe), .sa_en(sa_en), .sa_dout(sa_dout)
  );

  // Array model: cells take the driven data while a write wordline and the driver are on.
  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (mem_clr) mem[r] <= '0;
      else if (wdata_oe && row_wr_en[r]) mem[r] <= wdata_drv;
    end
  end

  always_comb begin
    sa_dout = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_rd_en[r]) sa_dout = mem[r];
    end
    if (stuck_en) sa_dout = stuck_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [ROWS-1:0] exp_row(input logic [AW-1:0] a);
    logic [ROWS-1:0] r;
    r = '0;
    if (int'(a) < ROWS) r[a] = 1'b1;
    return r;
  endfunction

  task automatic run_op(input logic we, input logic [AW-1:0] addr, input logic [COLS-1:0] data,
                        input int hold);
    int guard;
    int rd_start;
    logic [ROWS-1:0] row;
    logic in_rng;
    logic has_rsp;
    logic [COLS-1:0] exp_d;
    logic exp_e;
    row    = exp_row(addr);
    in_rng = int'(addr) < ROWS;
    has_rsp = we ? VERIFY : 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", 32'(guard < 50), 32'd1);
    @(posedge clk);
    if (we && in_rng) ref_mem[addr] = data;
    if (we) begin
      exp_d = in_rng ? (stuck_en ? stuck_val : data) : '0;
      exp_e = !in_rng || (exp_d != data);
    end else begin
      exp_d = in_rng ? ref_mem[addr] : '0;
      exp_e = !in_rng;
    end
    rd_start = 1;
    if (we) begin
      for (int k = 1; k <= 2 + WP; k++) begin
        @(negedge clk);
        check("wr_oe", 32'(wdata_oe), 32'd1);
        check("wr_drv", 32'(wdata_drv), 32'(data));
        check("wr_en", 32'(row_wr_en), 32'((k >= 2 && k <= 1 + WP) ? row : '0));
        check("wr_rd_en", 32'(row_rd_en | ROWS'(sa_en)), 32'd0);
        check("wr_ready", 32'(req_ready), 32'd0);
        req_valid = (k < 2 + WP) ? 1'($urandom_range(0, 1)) : 1'b0;
        req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = COLS'($urandom);
      end
      rd_start = 3 + WP;
    end
    if (has_rsp) begin
      for (int j = 0; j < RP; j++) begin
        @(negedge clk);
        check("rd_en", 32'(row_rd_en), 32'(row));
        check("rd_sa_en", 32'(sa_en), 32'(j == RP - 1));
        check("rd_wr_quiet", 32'(row_wr_en | ROWS'(wdata_oe)), 32'd0);
        check("rd_rsp_valid", 32'(rsp_valid | req_ready), 32'd0);
        req_valid = (j < RP - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        req_addr = AW'($urandom);
      end
      for (int h = 0; h <= hold; h++) begin
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
        check("rsp_err", 32'(rsp_err), 32'(exp_e));
        check("rsp_quiet", 32'(req_ready | sa_en | (|row_wr_en) | (|row_rd_en)), 32'd0);
        rsp_ready = (h == hold);
      end
    end
    @(negedge clk);
    check("end_ready", 32'(req_ready), 32'd1);
    check("end_quiet", 32'(rsp_valid | wdata_oe | sa_en), 32'd0);
    check("end_drv", 32'(wdata_drv), 32'd0);
    rsp_ready = 1'b0;
    if (rd_start < 0) check("unreachable", 32'd0, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [COLS-1:0] d;
    logic [AW-1:0]   a;
    rst_n = 1'b0; mem_clr = 1'b1; stuck_en = 1'b0; stuck_val = '0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int r = 0; r < ROWS; r++) ref_mem[r] = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_outs", 32'(rsp_valid | rsp_err | wdata_oe | sa_en), 32'd0);
    check("rst_vec", 32'({row_wr_en, row_rd_en, wdata_drv, rsp_rdata}), 32'd0);
    mem_clr = 1'b0;
    rst_n = 1'b1;
    #1 check("release_ready_early", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("release_ready", 32'(req_ready), 32'd1);

    run_op(1'b1, 2'd0, 8'hB7, 0);
    run_op(1'b0, 2'd0, 8'h00, 0);
    run_op(1'b1, 2'd1, 8'h5A, 0);
    run_op(1'b1, 2'd0, 8'hFF, 0);
    run_op(1'b0, 2'd1, 8'h00, 0);
    run_op(1'b0, 2'd0, 8'h00, 0);
    run_op(1'b0, 2'd1, 8'h00, 10);
    run_op(1'b0, 2'd3, 8'h00, 1);
    run_op(1'b1, 2'd3, 8'h99, 0);
    for (int r = 0; r < ROWS; r++) run_op(1'b0, AW'(r), 8'h00, 0);

    // Idle response acknowledge must do nothing.
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_rsp_ready", 32'({rsp_valid, req_ready}), 32'd1);
    end
    rsp_ready = 1'b0;

    // Reset in the second write-pulse cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd2; req_wdata = 8'h3C;
    @(posedge clk);
    ref_mem[2] = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_wr_en", 32'(row_wr_en), 32'(exp_row(2'd2)));
    #1 rst_n = 1'b0;
    #1;
    check("async_wr_en", 32'(row_wr_en), 32'd0);
    check("async_oe_sa", 32'(wdata_oe | sa_en | req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rerelease_early", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rerelease_ready", 32'(req_ready), 32'd1);
    run_op(1'b0, 2'd2, 8'h00, 0);

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    stuck_en = 1'b1; stuck_val = 8'hC2;
    run_op(1'b1, 2'd0, 8'hC3, 0);
    stuck_en = 1'b0;
    run_op(1'b1, 2'd1, 8'h66, 2);
`endif

    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom);
      d = COLS'($urandom);
      run_op(1'($urandom), a, d, int'($urandom_range(0, 3)));
    end
    for (int r = 0; r < ROWS; r++) run_op(1'b0, AW'(r), 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Digital access sequencer that drives the mixed-signal SRAM macro (write_driver, cell_array and sense_amp) from a valid/ready request port.
- Converts single-word read and write requests into timed wordline pulses, write-driver enables and sense-enable strobes, then captures the digitised sense-amp output.
- Sits between the system bus and the analog array; its row and data outputs are level-shifted to the VDD/VSS real-valued nets by the top-level wrapper.

Parameters:
- ROWS, 2, number of word rows in the array.
- COLS, 8, word width (array columns).
- WR_PULSE, 4, write-wordline high time in clk cycles (>=1).
- RD_PULSE, 4, read-wordline high time in clk cycles (>=2).
- AW, $clog2(ROWS) (min 1), address width.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  row address.
- req_wdata  in  COLS  write data.
- rsp_valid  out  1  read data (or error) available.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  COLS  read data.
- rsp_err  out  1  address out of range, or write-verify mismatch (see Optional Feature).
- row_wr_en  out  ROWS  one-hot write wordlines.
- row_rd_en  out  ROWS  one-hot read wordlines.
- wdata_drv  out  COLS  data to the write driver.
- wdata_oe  out  1  write-driver enable.
- sa_en  out  1  sense-amp enable strobe.
- sa_dout  in  COLS  digitised sense-amp output; valid while sa_en = 1.

Behaviour:
- Reset (async assert, sync deassert by the wrapper):
  - All outputs 0.
  - State IDLE; req_ready goes to 1 on the first clock edge after release.
- States: IDLE, WR_SETUP, WR_PULSE, WR_RECOV, RD_PULSE, RSP.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on an edge where req_valid && req_ready; req_we, req_addr and req_wdata are latched then.
  - Inputs outside that edge are ignored.
- Write, accepted at edge T:
  - T+1: WR_SETUP. wdata_drv = latched data, wdata_oe = 1.
  - T+2 .. T+1+WR_PULSE: WR_PULSE. row_wr_en[addr] = 1.
  - Next cycle: WR_RECOV. Wordline 0, wdata_oe still 1.
  - Then IDLE with wdata_oe = 0. Writes produce no response.
- Read, accepted at edge T:
  - T+1 .. T+RD_PULSE: RD_PULSE. row_rd_en[addr] = 1.
  - sa_en = 1 in the last pulse cycle only.
  - sa_dout is captured into rsp_rdata at the edge ending that cycle.
  - Then RSP: rsp_valid = 1, held stable with rsp_rdata until rsp_ready = 1.
  - Return to IDLE on the edge where rsp_valid && rsp_ready.
- Mutual exclusion: row_wr_en and row_rd_en are never both non-zero. At most one bit of either is set.
- Out-of-range address (req_addr >= ROWS):
  - No wordline is raised; the full timing sequence still runs.
  - A read returns rsp_rdata = 0, rsp_err = 1.
  - A write is silently dropped.
- Pulse counter: sized $clog2(max(WR_PULSE, RD_PULSE)) + 1 bits. Loaded on state entry, counts down, exits at 1.
- rsp_ready = 1 with rsp_valid = 0 has no effect.
- Reset mid-operation: all wordlines and strobes drop immediately (asynchronously); any pending response is lost.

Optional Feature:
- Macro SRAM_CTRL_WRITE_VERIFY_EN.
- Defined:
  - After WR_RECOV, the controller performs an automatic read of the same row (RD_PULSE sequence).
  - It compares the captured value against the written data, then enters RSP.
  - rsp_valid = 1 for writes as well; rsp_err = 1 on mismatch; rsp_rdata = the value read back.
- Not defined: writes produce no response, and rsp_err only reports out-of-range reads.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum typedef;
  - localparams for minimum pulse widths;
  - function onehot_row(addr, ROWS), returning the wordline vector or 0 when out of range.
- Sub-module sram_pulse_timer: loadable down-counter with a done flag, instantiated once and shared by the write and read pulses.

Test Plan:
- Write 8'hB7 to row 0, then read row 0, with the array model attached. Required: row_wr_en = 2'b01 for exactly 4 cycles starting 2 cycles after accept; row_rd_en = 2'b01 for 4 cycles; sa_en high only in the 4th read cycle; rsp_valid 5 cycles after accept; rsp_rdata = 8'hB7; rsp_err = 0.
- Write 8'h5A to row 1 and 8'hFF to row 0, then read both. Required: row 1 reads 8'h5A, row 0 reads 8'hFF, and each wordline is one-hot on the addressed row.
- Read accepted, rsp_ready held 0 for 10 cycles. Required: rsp_valid and rsp_rdata stable throughout, req_ready = 0, and no wordline activity.
- req_addr = 3 with ROWS = 3 (AW = 2), read. Required: no wordline, rsp_err = 1, rsp_rdata = 0; an out-of-range write changes no row contents.
- rst_n asserted during the 2nd cycle of a write pulse. Required: row_wr_en, wdata_oe and sa_en go to 0 without a clock edge, and req_ready = 1 one cycle after release.
- With SRAM_CTRL_WRITE_VERIFY_EN, write 8'hC3 with the model forced to stuck-at 8'hC2. Required: rsp_valid after the verify read, rsp_rdata = 8'hC2, rsp_err = 1.
